// File: rtl/dest_reader_pkg.sv
// Shared constants for the destination FIFO reader: word widths, buffer depth
// and the source encoding carried alongside each buffered word.
package dest_reader_pkg;

  localparam int BW        = 6;
  localparam int CNT_W     = 8;
  localparam int BUF_DEPTH = 2;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The registered pointer remembers who should win
// the next contested cycle and only moves when a grant is actually given.
module rr_arb2 import dest_reader_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_prio_d1;

  always_comb begin
    // NOTE: assign a default first so no path leaves o_gnt unassigned (no latch).
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = r_prio_d1 ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio_d1 <= 1'b0;
    end else if (init) begin
      r_prio_d1 <= 1'b0;
    end else if (o_gnt != 2'b00) begin
      r_prio_d1 <= o_gnt[0];
    end
  end

endmodule

// File: rtl/dest_reader.sv
// Drains two destination FIFOs round-robin into a 2-entry {src, data} output
// buffer, counting delivered words per source and masking sources that flag an error.
module dest_reader import dest_reader_pkg::*; #(
  parameter int BW    = dest_reader_pkg::BW,
  parameter int CNT_W = dest_reader_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic             D0_error_output,
  input  logic             D1_error_output,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic             error_out
);

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic             r_inflight_src;
  logic [BW-1:0]    r_buf_data [0:BUF_DEPTH-1];
  logic             r_buf_src  [0:BUF_DEPTH-1];
  logic [CNT_W-1:0] r_cnt_d0;
  logic [CNT_W-1:0] r_cnt_d1;
  logic             r_mask_d0;
  logic             r_mask_d1;
  logic             r_error;
  logic             r_run;

  logic             w_pop;
  logic [1:0]       w_after_pop;
  logic             w_tail;
  logic             w_can_read;
  logic [1:0]       w_elig;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic [BW-1:0]    w_cap_data;

  assign w_pop       = (r_occ != 2'd0) && out_ready;
  assign w_after_pop = r_occ - {1'b0, w_pop};
  assign w_tail      = w_after_pop[0];

  // Counting this cycle's pop frees a slot early enough to keep one word per cycle flowing.
  assign w_can_read = ({1'b0, w_after_pop} + {2'b00, r_inflight}) < 3'(BUF_DEPTH);

  assign w_elig = {!D1_empty && !D1_error_output && !r_mask_d1,
                   !D0_empty && !D0_error_output && !r_mask_d0};
  assign w_req  = w_elig & {2{w_can_read && r_run && !init}};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign D0_rd      = w_gnt[0];
  assign D1_rd      = w_gnt[1];
  assign w_cap_data = (r_inflight_src == SRC_D1) ? D1_data_out : D0_data_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ          <= 2'd0;
      r_inflight     <= 1'b0;
      r_inflight_src <= SRC_D0;
      // NOTE: the buffer words are reset too, because out_data must read 0 during reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_src[i]  <= SRC_D0;
      end
    end else if (init) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_src[0]  <= r_buf_src[1];
      end
      // A capture into slot 0 deliberately overrides the shift above.
      if (r_inflight) begin
        r_buf_data[w_tail] <= w_cap_data;
        r_buf_src[w_tail]  <= r_inflight_src;
      end
      r_occ          <= w_after_pop + {1'b0, r_inflight};
      r_inflight     <= D0_rd || D1_rd;
      r_inflight_src <= D1_rd ? SRC_D1 : SRC_D0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_d0  <= '0;
      r_cnt_d1  <= '0;
      r_mask_d0 <= 1'b0;
      r_mask_d1 <= 1'b0;
      r_error   <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (init) begin
        r_cnt_d0  <= '0;
        r_cnt_d1  <= '0;
        r_mask_d0 <= 1'b0;
        r_mask_d1 <= 1'b0;
        r_error   <= 1'b0;
      end else begin
        if (w_pop && (r_buf_src[0] == SRC_D1)) begin
          r_cnt_d1 <= r_cnt_d1 + CNT_W'(1);
        end else if (w_pop) begin
          r_cnt_d0 <= r_cnt_d0 + CNT_W'(1);
        end
        if (D0_error_output) r_mask_d0 <= 1'b1;
        if (D1_error_output) r_mask_d1 <= 1'b1;
        r_error <= r_error || D0_error_output || D1_error_output;
      end
    end
  end

  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_buf_data[0];
  assign out_src   = r_buf_src[0];
  assign cnt_D0    = r_cnt_d0;
  assign cnt_D1    = r_cnt_d1;
  assign error_out = r_error;

endmodule
